pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the stall and flush inputs of the PC register and the fd, de, em and mw pipeline registers. It resolves load-use hazards, branch redirects, multi-cycle data-memory waits and debug halt/drain requests. Stall/flush outputs are combinational from registered FSM state plus current-cycle hazard inputs, so they take effect at the next clock edge.

## Interface
- MEM_TIMEOUT, 256: data-memory wait cycles before mem_err is set.
- CNT_W, 32: performance counter width.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- d_rs1, d_rs2  in  5 each  source registers of the instruction in Decode (fd_reg output)
- d_uses_rs1, d_uses_rs2  in  1 each  Decode instruction reads rs1 / rs2
- e_valid, e_is_load  in  1 each  Execute holds a valid instruction / a load
- e_rd  in  5  Execute destination register
- e_redirect  in  1  branch/jump resolved taken in Execute
- m_valid, m_mem  in  1 each  Memory stage holds a valid instruction / a load or store
- w_valid  in  1  Writeback stage valid (mw_reg out_valid)
- dmem_ready  in  1  data memory completes the access this cycle
- halt_req, resume  in  1 each  debug halt request / resume
- pc_stall  out  1  hold PC
- fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_stall, mw_flush  out  1 each
- halted  out  1  pipeline drained and frozen
- mem_err  out  1  sticky, memory wait exceeded MEM_TIMEOUT
- stall_cycles, flush_events  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state: RUN.
- mem_busy = m_valid & m_mem & ~dmem_ready.
- load_use = e_valid & e_is_load & (e_rd != 0) & ((d_uses_rs1 & d_rs1 == e_rd) | (d_uses_rs2 & d_rs2 == e_rd)).
- Priority is highest first:
  1. mem_busy: pc, fd, de and em stall; mw_flush; all other outputs 0. e_redirect and load_use are ignored because Execute is held and re-presents them.
  2. e_redirect: fd_flush and de_flush; pc not stalled, so the PC loads the target.
  3. load_use: pc_stall, fd_stall, de_flush (one bubble per cycle while the hazard persists).
  4. DRAIN or HALTED with no higher cause: pc_stall, fd_stall, de_flush.
- Transitions:
  - RUN to MEM_WAIT when mem_busy.
  - MEM_WAIT to RUN on dmem_ready, or to DRAIN if halt_pending.
  - RUN to DRAIN on halt_req when not mem_busy. halt_req during MEM_WAIT sets halt_pending.
  - DRAIN to HALTED when e_valid=0, m_valid=0 and w_valid=0.
  - HALTED to RUN on resume. resume in any other state is ignored.
- Wait counter: cleared on entry to MEM_WAIT. Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_err. The FSM keeps waiting.
- em_stall, mw_stall and em_flush are only ever asserted as listed above; all unlisted outputs are 0.
- Reset values of all outputs: 0 (state RUN, mem_err 0, counters 0, halt_pending 0).

## Timing
- Zero-cycle decision: outputs reflect this cycle's inputs; state/counters update at the edge.
- halted is registered: 1 in the cycle after DRAIN detects an empty E/M/W.
- Redirect during DRAIN: honoured (pc loads target, fd/de flushed); drain continues next cycle.
- Simultaneous halt_req and resume in HALTED: resume wins, halt_req ignored.
- Simultaneous dmem_ready and halt_pending: go to DRAIN, not RUN.
- rst mid-MEM_WAIT or mid-DRAIN: state RUN, pending halt dropped, mem_err cleared.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments each cycle pc_stall=1.
  - flush_events increments each cycle any *_flush=1.
  - Both wrap modulo 2^CNT_W and clear on rst.
- Not defined: counter logic is absent and stall_cycles = flush_events = 0 constantly. Ports always exist.

## Structure
- Shared package pipe_pkg holds:
  - the hazard FSM enum type hz_state_t (RUN, MEM_WAIT, DRAIN, HALTED);
  - the REG_X0 constant (5'd0);
  - DWIDTH/ZERO_DW, as already used by the pipeline registers.
- Sub-module load_use_detect: purely combinational, produces load_use from the d_* and e_* inputs.

## Test plan
- Load-use: e_is_load=1, e_rd=5, d_rs1=5, d_uses_rs1=1 for one cycle -> pc_stall=fd_stall=de_flush=1 that cycle; e_rd=0 with d_rs1=0 -> no stall.
- Memory wait: m_mem=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles of pc/fd/de/em stall + mw_flush, state MEM_WAIT, RUN after ready. MEM_TIMEOUT=4 with 6-cycle wait -> mem_err=1 from the 5th wait cycle and stays set.
- Priority: e_redirect=1 with mem_busy=1 -> only mem-wait outputs; next cycle dmem_ready=1 -> fd_flush=de_flush=1.
- Halt: halt_req with E/M/W valid for 2 more cycles -> DRAIN, halted=1 on cycle 4; resume -> halted=0, all stalls drop.
- Reset mid-DRAIN -> all outputs 0 the next cycle; with PIPE_PERF_CNT_EN, 10 load-use cycles -> stall_cycles=10, flush_events=10.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and constants
package pipe_pkg;
    localparam int DWIDTH = 32;
    localparam logic [DWIDTH-1:0] ZERO_DW = '0;
    localparam logic [4:0] REG_X0 = 5'd0;
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags a Decode source that depends on a load still in Execute
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] d_rs1_i,
    input  logic [4:0] d_rs2_i,
    input  logic       d_uses_rs1_i,
    input  logic       d_uses_rs2_i,
    input  logic       e_valid_i,
    input  logic       e_is_load_i,
    input  logic [4:0] e_rd_i,
    output logic       load_use_o
);
    assign load_use_o = e_valid_i & e_is_load_i & (e_rd_i != REG_X0) &
                        ((d_uses_rs1_i & (d_rs1_i == e_rd_i)) | (d_uses_rs2_i & (d_rs2_i == e_rd_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipe; PIPE_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_uses_rs1,
    input  logic             d_uses_rs2,
    input  logic             e_valid,
    input  logic             e_is_load,
    input  logic [4:0]       e_rd,
    input  logic             e_redirect,
    input  logic             m_valid,
    input  logic             m_mem,
    input  logic             w_valid,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             em_flush,
    output logic             mw_stall,
    output logic             mw_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    hz_state_t state_q, state_d;
    logic halt_pend_q, halt_pend_d;
    logic [WC_W-1:0] wait_q, wait_d;
    logic mem_err_q, mem_err_d;
    logic load_use, mem_busy, freeze;

    load_use_detect u_lud (
        .d_rs1_i     (d_rs1),
        .d_rs2_i     (d_rs2),
        .d_uses_rs1_i(d_uses_rs1),
        .d_uses_rs2_i(d_uses_rs2),
        .e_valid_i   (e_valid),
        .e_is_load_i (e_is_load),
        .e_rd_i      (e_rd),
        .load_use_o  (load_use)
    );

    // A memory wait holds everything up to Memory, so Execute re-presents redirect/load-use later
    assign mem_busy = m_valid & m_mem & ~dmem_ready;
    assign freeze   = load_use | (state_q == DRAIN) | (state_q == HALTED);
    assign pc_stall = mem_busy | (~e_redirect & freeze);
    assign fd_stall = pc_stall;
    assign fd_flush = ~mem_busy & e_redirect;
    assign de_stall = mem_busy;
    assign de_flush = ~mem_busy & (e_redirect | freeze);
    assign em_stall = mem_busy;
    assign em_flush = 1'b0;
    assign mw_stall = 1'b0;
    assign mw_flush = mem_busy;
    assign halted   = state_q == HALTED;
    assign mem_err  = mem_err_q;

    // Next state, halt deferred across a memory wait, and saturating wait timeout
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        wait_d      = wait_q;
        case (state_q)
            RUN: begin
                wait_d  = '0;
                state_d = mem_busy ? MEM_WAIT : (halt_req ? DRAIN : RUN);
            end
            MEM_WAIT: begin
                wait_d      = (wait_q == WC_MAX) ? wait_q : wait_q + 1'b1;
                halt_pend_d = (halt_pend_q | halt_req) & ~dmem_ready;
                state_d     = ~dmem_ready ? MEM_WAIT : ((halt_pend_q | halt_req) ? DRAIN : RUN);
            end
            DRAIN:   state_d = (~e_valid & ~m_valid & ~w_valid) ? HALTED : DRAIN;
            HALTED:  state_d = resume ? RUN : HALTED;
            default: state_d = RUN;
        endcase
        mem_err_d = mem_err_q | ((state_q == MEM_WAIT) & (wait_d == WC_MAX));
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            halt_pend_q <= 1'b0;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Count PC-stall cycles and cycles carrying any flush; both wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_q + CNT_W'(pc_stall);
            flush_q <= flush_q + CNT_W'(fd_flush | de_flush | em_flush | mw_flush);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized and directed checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 32;
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] d_rs1, d_rs2, e_rd;
    logic d_uses_rs1, d_uses_rs2, e_valid, e_is_load, e_redirect;
    logic m_valid, m_mem, w_valid, dmem_ready, halt_req, resume;
    logic pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_stall, mw_flush;
    logic halted, mem_err;
    logic [CW-1:0] stall_cycles, flush_events;
    logic [10:0] outs, exp_o;

    int mode, waited, passed, total;
    bit pend, err;
    int n_stall, n_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1),
        .d_uses_rs2(d_uses_rs2), .e_valid(e_valid), .e_is_load(e_is_load), .e_rd(e_rd),
        .e_redirect(e_redirect), .m_valid(m_valid), .m_mem(m_mem), .w_valid(w_valid),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume), .pc_stall(pc_stall),
        .fd_stall(fd_stall), .fd_flush(fd_flush), .de_stall(de_stall), .de_flush(de_flush),
        .em_stall(em_stall), .em_flush(em_flush), .mw_stall(mw_stall), .mw_flush(mw_flush),
        .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    assign outs = {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush,
                   mw_stall, mw_flush, halted, mem_err};

    function automatic logic [10:0] predict();
        bit busy, lu, hold, pc, fdf, def;
        busy = m_valid && m_mem && !dmem_ready;
        lu = e_valid && e_is_load && e_rd != 0 &&
             ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd));
        hold = lu || mode == M_DRAIN || mode == M_HALT;
        pc  = busy ? 1'b1 : (e_redirect ? 1'b0 : hold);
        fdf = !busy && e_redirect;
        def = !busy && (e_redirect || hold);
        return {pc, pc, fdf, busy, def, busy, 1'b0, 1'b0, busy, mode == M_HALT, err};
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef PIPE_PERF_CNT_EN
        return CW'(n);
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        logic [10:0] e;
        e = predict();
        if (rst) begin
            mode = M_RUN; pend = 0; err = 0; waited = 0; n_stall = 0; n_flush = 0;
        end else begin
            n_stall += int'(e[10]);
            n_flush += int'(e[8] | e[6] | e[4] | e[2]);
            case (mode)
                M_RUN: begin
                    if (m_valid && m_mem && !dmem_ready) begin mode = M_WAIT; waited = 0; end
                    else if (halt_req) mode = M_DRAIN;
                end
                M_WAIT: begin
                    waited++;
                    if (waited >= TO) err = 1;
                    if (halt_req) pend = 1;
                    if (dmem_ready) begin mode = pend ? M_DRAIN : M_RUN; pend = 0; end
                end
                M_DRAIN: if (!e_valid && !m_valid && !w_valid) mode = M_HALT;
                default: if (resume) mode = M_RUN;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; d_rs1 = 0; d_rs2 = 0; e_rd = 0; d_uses_rs1 = 0; d_uses_rs2 = 0;
        e_valid = 0; e_is_load = 0; e_redirect = 0; m_valid = 0; m_mem = 0;
        w_valid = 0; dmem_ready = 0; halt_req = 0; resume = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; m_valid = 1; m_mem = 1; halt_req = 1;
        tick();
        tick();
        idle();
        #1;
        total++;
        if (outs !== 11'd0 || stall_cycles !== '0 || flush_events !== '0)
            $display("FAIL reset: outs=%b stall=%0d flush=%0d want all 0", outs, stall_cycles, flush_events);
        else passed++;
    endtask

    task automatic test_load_use();
        idle();
        e_valid = 1; e_is_load = 1; e_rd = 5; d_rs1 = 5; d_uses_rs1 = 1;
        #1;
        total++;
        if (!(pc_stall === 1 && fd_stall === 1 && de_flush === 1) || outs !== predict())
            $display("FAIL load_use_hit: outs=%b want %b", outs, predict());
        else passed++;
        tick();
        e_rd = 0; d_rs1 = 0;
        #1;
        total++;
        if (outs !== 11'd0) $display("FAIL load_use_x0: outs=%b want 0", outs);
        else passed++;
        tick();
        for (int i = 0; i < 60; i++) begin
            idle();
            d_rs1 = 5'($urandom_range(0, 3)); d_rs2 = 5'($urandom_range(0, 3));
            e_rd = 5'($urandom_range(0, 3));
            d_uses_rs1 = 1'($urandom); d_uses_rs2 = 1'($urandom);
            e_valid = 1'($urandom); e_is_load = 1'($urandom);
            e_redirect = ($urandom_range(0, 4) == 0);
            #1;
            exp_o = predict();
            total++;
            if (outs !== exp_o) $display("FAIL load_use_rand %0d: outs=%b want %b", i, outs, exp_o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_mem_wait();
        for (int k = 0; k < 2; k++) begin
            int busy_n = (k == 0) ? 3 : 6;
            for (int i = 0; i <= busy_n + 2; i++) begin
                idle();
                m_valid = (i <= busy_n); m_mem = (i <= busy_n); dmem_ready = (i == busy_n);
                #1;
                exp_o = predict();
                total++;
                if (outs !== exp_o) $display("FAIL mem_wait%0d cyc %0d: outs=%b want %b", busy_n, i, outs, exp_o);
                else passed++;
                tick();
            end
        end
        total++;
        if (mem_err !== 1'b1) $display("FAIL mem_err_sticky: mem_err=%b want 1", mem_err);
        else passed++;
        test_reset();
    endtask

    task automatic test_priority();
        idle();
        m_valid = 1; m_mem = 1; e_redirect = 1;
        #1;
        total++;
        if (outs !== 11'b11010100100 || outs !== predict())
            $display("FAIL prio_mem_over_redirect: outs=%b want %b", outs, predict());
        else passed++;
        tick();
        dmem_ready = 1;
        #1;
        total++;
        if (outs !== 11'b00101000000 || outs !== predict())
            $display("FAIL prio_redirect_after_ready: outs=%b want %b", outs, predict());
        else passed++;
        tick();
    endtask

    task automatic test_halt();
        for (int i = 0; i < 9; i++) begin
            idle();
            e_valid = (i < 2); m_valid = (i < 2); w_valid = (i < 2);
            halt_req = (i == 0);
            e_redirect = (i == 1);
            resume = (i == 6);
            halt_req = halt_req | (i == 6);
            #1;
            exp_o = predict();
            total++;
            if (outs !== exp_o) $display("FAIL halt cyc %0d: outs=%b want %b", i, outs, exp_o);
            else passed++;
            if (i == 3) begin
                total++;
                if (halted !== 1'b1) $display("FAIL halted_cycle4: halted=%b want 1", halted);
                else passed++;
            end
            tick();
        end
        total++;
        if (outs !== 11'd0) $display("FAIL resume: outs=%b want 0", outs);
        else passed++;
    endtask

    task automatic test_reset_mid_drain();
        idle();
        halt_req = 1; e_valid = 1;
        tick();
        halt_req = 0;
        tick();
        rst = 1;
        tick();
        idle();
        #1;
        total++;
        if (outs !== 11'd0 || outs !== predict()) $display("FAIL reset_mid_drain: outs=%b want 0", outs);
        else passed++;
    endtask

    task automatic test_perf();
        test_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            e_valid = 1; e_is_load = 1; e_rd = 7; d_rs2 = 7; d_uses_rs2 = 1;
            tick();
        end
        idle();
        #1;
        total++;
        if (stall_cycles !== exp_cnt(10) || flush_events !== exp_cnt(10) || n_stall != 10)
            $display("FAIL perf_10_load_use: stall=%0d flush=%0d want %0d", stall_cycles, flush_events, exp_cnt(10));
        else passed++;
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 2000; i++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            d_rs1 = 5'($urandom_range(0, 3)); d_rs2 = 5'($urandom_range(0, 3));
            e_rd = 5'($urandom_range(0, 3));
            d_uses_rs1 = 1'($urandom); d_uses_rs2 = 1'($urandom);
            e_valid = 1'($urandom); e_is_load = 1'($urandom);
            e_redirect = ($urandom_range(0, 5) == 0);
            m_valid = 1'($urandom); m_mem = 1'($urandom); w_valid = 1'($urandom);
            dmem_ready = ($urandom_range(0, 2) == 0);
            halt_req = ($urandom_range(0, 24) == 0);
            resume = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin e_valid = 0; m_valid = 0; w_valid = 0; end
            #1;
            exp_o = predict();
            total++;
            if (outs !== exp_o || stall_cycles !== exp_cnt(n_stall) || flush_events !== exp_cnt(n_flush))
                $display("FAIL random %0d: outs=%b want %b stall=%0d want %0d flush=%0d want %0d",
                         i, outs, exp_o, stall_cycles, exp_cnt(n_stall), flush_events, exp_cnt(n_flush));
            else passed++;
            tick();
        end
    endtask

    initial begin
        passed = 0; total = 0;
        mode = M_RUN; pend = 0; err = 0; waited = 0; n_stall = 0; n_flush = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mem_wait();
        test_priority();
        test_halt();
        test_reset_mid_drain();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
